// File: rtl/squash_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: captures squashed tags, returns them to the free list, then redirects fetch.
// Optional macro SQUASH_EX_WAIT_EN inserts WAIT_EX so the redirect also waits for ex_idle.
module squash_recovery_ctrl #(
  parameter int N_ROB    = 32,
  parameter int N_WAY    = 2,
  parameter int CDB_BITS = 6,
  parameter int XLEN     = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              branch_haz,
  input  logic [N_ROB-1:0][CDB_BITS-1:0]    squash_tags,
  input  logic [XLEN-1:0]                   br_target_pc,
  input  logic                              free_ready,
  input  logic                              ex_idle,
  output logic                              stall_dispatch,
  output logic [N_WAY-1:0]                  free_valid,
  output logic [N_WAY-1:0][CDB_BITS-1:0]    free_tag,
  output logic                              redirect_valid,
  output logic [XLEN-1:0]                   redirect_pc,
  output logic [$clog2(N_ROB):0]            squash_count,
  output logic                              busy
);

  localparam int CW = $clog2(N_ROB) + 1;

`ifdef SQUASH_EX_WAIT_EN
  typedef enum logic [1:0] {IDLE, DRAIN, WAIT_EX, REDIRECT} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;
  logic unused_ex_idle;
  assign unused_ex_idle = ex_idle;
`endif

  state_t                           state_q, state_d;
  logic [N_ROB-1:0][CDB_BITS-1:0]   pend_q, pend_d;
  logic [XLEN-1:0]                  pc_q, pc_d;
  logic [CW-1:0]                    count_q, count_d;
  logic                             redirect_valid_q, redirect_valid_d;
  logic [XLEN-1:0]                  redirect_pc_q, redirect_pc_d;
  logic                             busy_q, busy_d;

  logic [N_ROB-1:0]                 nz_mask;
  logic [N_ROB-1:0]                 take_mask;
  logic [N_ROB-1:0]                 remaining;
  logic [N_WAY-1:0]                 lane_valid;
  logic [N_WAY-1:0][CDB_BITS-1:0]   lane_tag;
  logic [CW-1:0]                    add_cnt;
  logic [CW:0]                      sum_cnt;
  logic                             found;

  // Each lane claims the lowest-index nonzero entry not already taken by a lower lane.
  always_comb begin
    nz_mask    = '0;
    take_mask  = '0;
    lane_valid = '0;
    lane_tag   = '0;
    add_cnt    = '0;
    found      = 1'b0;
    for (int e = 0; e < N_ROB; e++) begin
      nz_mask[e] = (pend_q[e] != '0);
    end
    remaining = nz_mask;
    for (int i = 0; i < N_WAY; i++) begin
      found = 1'b0;
      for (int e = 0; e < N_ROB; e++) begin
        if (!found && remaining[e]) begin
          found         = 1'b1;
          lane_valid[i] = 1'b1;
          lane_tag[i]   = pend_q[e];
          remaining[e]  = 1'b0;
          take_mask[e]  = 1'b1;
        end
      end
      add_cnt = add_cnt + CW'(lane_valid[i]);
    end
    sum_cnt = {1'b0, count_q} + {1'b0, add_cnt};
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    pc_d    = pc_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (branch_haz) begin
          pend_d  = squash_tags;
          pc_d    = br_target_pc;
          count_d = '0;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (free_ready) begin
          for (int e = 0; e < N_ROB; e++) begin
            if (take_mask[e]) pend_d[e] = '0;
          end
          count_d = (sum_cnt > (CW+1)'(N_ROB)) ? CW'(N_ROB) : sum_cnt[CW-1:0];
        end
        // An empty buffer exits even without free_ready: there is nothing to hand over.
        if (nz_mask == '0 || (free_ready && (nz_mask & ~take_mask) == '0)) begin
`ifdef SQUASH_EX_WAIT_EN
          state_d = WAIT_EX;
`else
          state_d = REDIRECT;
`endif
        end
      end
`ifdef SQUASH_EX_WAIT_EN
      WAIT_EX: begin
        if (ex_idle) state_d = REDIRECT;
      end
`endif
      REDIRECT: state_d = IDLE;
      default:  state_d = IDLE;
    endcase
    redirect_valid_d = (state_d == REDIRECT);
    redirect_pc_d    = (state_d == REDIRECT) ? pc_d : '0;
    busy_d           = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= IDLE;
      pend_q           <= '0;
      pc_q             <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      busy_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      pend_q           <= pend_d;
      pc_q             <= pc_d;
      count_q          <= count_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      busy_q           <= busy_d;
    end
  end

  assign stall_dispatch = branch_haz | busy_q;
  assign free_valid     = (state_q == DRAIN) ? lane_valid : '0;
  assign free_tag       = (state_q == DRAIN) ? lane_tag   : '0;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign squash_count   = count_q;
  assign busy           = busy_q;

endmodule
